// File: rtl/soc_uart.sv
// soc_uart: memory-mapped 8N1 UART with a programmable baud divider and an RX FIFO.
// Ports: clk/reset (sync, active-high); ser_tx/ser_rx are the pads;
//   reg_div_* is the divider register; reg_dat_* is the data register (write = TX, read = RX pop);
//   rx_overrun/rx_frame_err are sticky error flags, and err_clr clears them.
module soc_uart #(
   parameter int unsigned DEFAULT_DIV = 104,
   parameter int unsigned RX_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ser_tx,
   input  logic        ser_rx,
   input  logic [3:0]  reg_div_we,
   input  logic [31:0] reg_div_di,
   output logic [31:0] reg_div_do,
   input  logic        reg_dat_we,
   input  logic        reg_dat_re,
   input  logic [31:0] reg_dat_di,
   output logic [31:0] reg_dat_do,
   output logic        reg_dat_wait,
   output logic        rx_overrun,
   output logic        rx_frame_err,
   input  logic        err_clr
);
   localparam int PW = $clog2(RX_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   // ---------------- divider ----------------
   logic [31:0] div_q, div_d, bit_len;
   // Very small divisors are clamped so that half a bit is always at least 2 cycles.
   assign bit_len = (div_q < 32'd4) ? 32'd4 : div_q;

   always_comb begin
      div_d = div_q;
      for (int i = 0; i < 4; i++)
         if (reg_div_we[i]) div_d[8*i +: 8] = reg_div_di[8*i +: 8];
   end

   // ---------------- transmitter ----------------
   state_e      tx_state_q, tx_state_d;
   logic [31:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_q, tx_d;
   logic        unused_dat_di;

   assign unused_dat_di = ^reg_dat_di[31:8];

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      // Bit counters are reloaded from bit_len only at bit boundaries, so a
      // divider write mid-frame applies from the next bit onwards.
      case (tx_state_q)
         S_IDLE: if (reg_dat_we) begin
            tx_shift_d = reg_dat_di[7:0];
            tx_cnt_d   = bit_len - 32'd1;
            tx_state_d = S_START;
         end
         S_START: if (tx_cnt_q == 32'd0) begin
            tx_state_d = S_DATA;
            tx_cnt_d   = bit_len - 32'd1;
            tx_bit_d   = 3'd0;
         end else tx_cnt_d = tx_cnt_q - 32'd1;
         S_DATA: if (tx_cnt_q == 32'd0) begin
            if (tx_bit_q == 3'd7) begin
               // The IDLE cycle that follows is the last stop-bit cycle, so
               // STOP itself lasts one cycle less; a held write then starts
               // its start bit straight after a full-length stop bit.
               tx_state_d = S_STOP;
               tx_cnt_d   = bit_len - 32'd2;
            end else begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               tx_cnt_d   = bit_len - 32'd1;
            end
         end else tx_cnt_d = tx_cnt_q - 32'd1;
         S_STOP: if (tx_cnt_q == 32'd0) tx_state_d = S_IDLE;
                 else tx_cnt_d = tx_cnt_q - 32'd1;
         default: tx_state_d = S_IDLE;
      endcase
      // Pad output registered from next state to keep ser_tx glitch-free.
      tx_d = 1'b1;
      if (tx_state_d == S_START)     tx_d = 1'b0;
      else if (tx_state_d == S_DATA) tx_d = tx_shift_d[0];
   end

   assign ser_tx       = tx_q;
   assign reg_dat_wait = reg_dat_we & (tx_state_q != S_IDLE);

   // ---------------- receiver ----------------
   logic        rx_meta_q, rxs_q;
   state_e      rx_state_q, rx_state_d;
   logic [31:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_push, ferr_set;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      ferr_set   = 1'b0;
      case (rx_state_q)
         S_IDLE: if (!rxs_q) begin
            rx_state_d = S_START;
            rx_cnt_d   = (bit_len >> 1) - 32'd1;
         end
         S_START: if (rx_cnt_q == 32'd0) begin
            if (rxs_q) rx_state_d = S_IDLE;   // false start
            else begin
               rx_state_d = S_DATA;
               rx_cnt_d   = bit_len - 32'd1;
               rx_bit_d   = 3'd0;
            end
         end else rx_cnt_d = rx_cnt_q - 32'd1;
         S_DATA: if (rx_cnt_q == 32'd0) begin
            rx_shift_d = {rxs_q, rx_shift_q[7:1]};
            rx_cnt_d   = bit_len - 32'd1;
            if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
         end else rx_cnt_d = rx_cnt_q - 32'd1;
         S_STOP: if (rx_cnt_q == 32'd0) begin
            rx_state_d = S_IDLE;
            rx_push    = rxs_q;
            ferr_set   = ~rxs_q;
         end else rx_cnt_d = rx_cnt_q - 32'd1;
         default: rx_state_d = S_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]    fifo_mem_q [RX_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          fifo_empty, fifo_full, pop, push_ok, ovr_set;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(RX_DEPTH));
   assign pop        = reg_dat_re & ~fifo_empty;
   // A simultaneous pop frees a slot for the incoming byte even when full.
   assign push_ok    = rx_push & (~fifo_full | pop);
   assign ovr_set    = rx_push & fifo_full & ~pop;
   assign reg_dat_do = fifo_empty ? 32'hFFFF_FFFF : {24'b0, fifo_mem_q[rd_ptr_q]};

   always_ff @(posedge clk)
      if (push_ok) fifo_mem_q[wr_ptr_q] <= rx_shift_q;

   // ---------------- state registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q        <= 32'(DEFAULT_DIV);
         tx_state_q   <= S_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         tx_q         <= 1'b1;
         rx_meta_q    <= 1'b1;
         rxs_q        <= 1'b1;
         rx_state_q   <= S_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         div_q      <= div_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
         rx_meta_q  <= ser_rx;
         rxs_q      <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push_ok && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push_ok) count_q <= count_q - CW'(1);
         // Setting an error wins over a clear in the same cycle.
         if (ovr_set)      rx_overrun   <= 1'b1;
         else if (err_clr) rx_overrun   <= 1'b0;
         if (ferr_set)     rx_frame_err <= 1'b1;
         else if (err_clr) rx_frame_err <= 1'b0;
      end
   end

   assign reg_div_do = div_q;
endmodule

// File: tb/tb_soc_uart.sv
module tb_soc_uart;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, ser_tx, ser_rx, rx_drv, loopback;
   logic [3:0]  reg_div_we;
   logic [31:0] reg_div_di, reg_div_do, reg_dat_di, reg_dat_do;
   logic        reg_dat_we, reg_dat_re, reg_dat_wait;
   logic        rx_overrun, rx_frame_err, err_clr;

   always #5 clk = ~clk;

   assign ser_rx = loopback ? ser_tx : rx_drv;

   soc_uart #(.DEFAULT_DIV(104), .RX_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .ser_tx(ser_tx), .ser_rx(ser_rx),
      .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
      .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
      .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait),
      .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .err_clr(err_clr)
   );

   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [7:0]  model_q [$];
   logic        exp_ovr, exp_ferr;
   logic [31:0] model_div;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int eff_d(input logic [31:0] v);
      return (v < 32'd4) ? 4 : int'(v);
   endfunction

   // Line level of bit slot i (0 = start, 1..8 = data LSB first, 9 = stop).
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   function automatic logic [31:0] exp_dat();
      return (model_q.size() != 0) ? {24'b0, model_q[0]} : 32'hFFFF_FFFF;
   endfunction

   task automatic model_push(input logic [7:0] b);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else exp_ovr = 1'b1;
   endtask

   task automatic check_rx(input string tag);
      check({tag, ".dat"},  reg_dat_do, exp_dat());
      check({tag, ".ovr"},  32'(rx_overrun), 32'(exp_ovr));
      check({tag, ".ferr"}, 32'(rx_frame_err), 32'(exp_ferr));
   endtask

   task automatic set_div(input logic [3:0] we, input logic [31:0] di);
      for (int i = 0; i < 4; i++)
         if (we[i]) model_div[8*i +: 8] = di[8*i +: 8];
      reg_div_we = we; reg_div_di = di;
      @(negedge clk);
      reg_div_we = 4'h0;
      check("div.do", reg_div_do, model_div);
   endtask

   task automatic pop_one(input string tag);
      check(tag, reg_dat_do, exp_dat());
      reg_dat_re = 1'b1;
      @(negedge clk);
      reg_dat_re = 1'b0;
      if (model_q.size() != 0) void'(model_q.pop_front());
   endtask

   task automatic clear_flags();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_ovr = 1'b0; exp_ferr = 1'b0;
   endtask

   // Two writes held back-to-back: frame a, then frame b with no gap.
   task automatic tx_pair(input logic [7:0] a, input logic [7:0] b);
      int d;
      logic [7:0] cur;
      d = eff_d(model_div);
      reg_dat_we = 1'b1; reg_dat_di = {24'b0, a};
      for (int k = 0; k < 20*d; k++) begin
         @(negedge clk);
         cur = (k < 10*d) ? a : b;
         check("tx.bit", 32'(ser_tx), 32'(frame_bit(cur, (k % (10*d)) / d)));
         if (k < 10*d)
            check("tx.wait", 32'(reg_dat_wait), (k == 10*d-1) ? 32'd0 : 32'd1);
         if (k == 0)    reg_dat_di = {24'b0, b};
         if (k == 10*d) reg_dat_we = 1'b0;
      end
      @(negedge clk);
      check("tx.idle", 32'(ser_tx), 32'd1);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      int d;
      d = eff_d(model_div);
      for (int i = 0; i < 10; i++) begin
         rx_drv = (i == 9) ? stop : frame_bit(b, i);
         repeat (d) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (2*d) @(negedge clk);
      if (stop) model_push(b);
      else      exp_ferr = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, n;
      reset = 1'b1; rx_drv = 1'b1; loopback = 1'b0;
      reg_div_we = 4'h0; reg_div_di = '0; reg_dat_we = 1'b0; reg_dat_re = 1'b0;
      reg_dat_di = '0; err_clr = 1'b0;
      exp_ovr = 1'b0; exp_ferr = 1'b0; model_div = 32'd104;
      repeat (3) @(negedge clk);
      check("rst.tx",   32'(ser_tx), 32'd1);
      check("rst.div",  reg_div_do, 32'd104);
      check("rst.dat",  reg_dat_do, 32'hFFFF_FFFF);
      check("rst.wait", 32'(reg_dat_wait), 32'd0);
      check("rst.ovr",  32'(rx_overrun), 32'd0);
      check("rst.ferr", 32'(rx_frame_err), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // TX framing, divider 8 then a random divider (values below 4 clamp).
      set_div(4'hF, 32'd8);
      tx_pair(8'hA5, 8'($urandom));
      set_div(4'hF, 32'($urandom_range(0, 12)));
      tx_pair(8'($urandom), 8'($urandom));

      // Loopback TX -> RX.
      set_div(4'hF, 32'd8);
      d = eff_d(model_div);
      loopback = 1'b1;
      reg_dat_we = 1'b1; reg_dat_di = 32'h3C;
      @(negedge clk);
      reg_dat_we = 1'b0;
      repeat (12*d) @(negedge clk);
      model_push(8'h3C);
      check_rx("loop");
      pop_one("loop.pop");
      check_rx("loop.empty");
      loopback = 1'b0;

      // Overrun: five frames, no reads.
      for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
      check_rx("ovr");
      for (int i = 0; i < 4; i++) pop_one("ovr.pop");
      check_rx("ovr.drained");
      clear_flags();
      check_rx("ovr.clr");

      // Random frames and reads, exercising pointer wrap and occasional framing errors.
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 3);
         for (int f = 0; f < n; f++)
            rx_frame(8'($urandom), ($urandom_range(0, 5) != 0));
         check_rx("rnd");
         n = $urandom_range(0, 3);
         for (int p = 0; p < n; p++) pop_one("rnd.pop");
      end
      while (model_q.size() != 0) pop_one("drain");
      clear_flags();
      check_rx("clean");

      // Short glitch is a false start; a low stop bit is a framing error.
      rx_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3*d) @(negedge clk);
      check_rx("glitch");
      rx_frame(8'h5A, 1'b0);
      check_rx("ferr");
      clear_flags();
      check_rx("ferr.clr");

      // Byte-lane divider writes, then a clamped divider of 2.
      set_div(4'b0001, 32'h0000_0002);
      for (int i = 0; i < 4; i++) set_div(4'($urandom), $urandom);
      set_div(4'hF, 32'd2);
      tx_pair(8'($urandom), 8'($urandom));

      // Reset in the middle of a frame with a byte waiting in the FIFO.
      rx_frame(8'($urandom), 1'b1);
      check_rx("pre.rst");
      reg_dat_we = 1'b1; reg_dat_di = 32'h00;
      @(negedge clk);
      reg_dat_we = 1'b0;
      repeat ($urandom_range(2, 30)) @(negedge clk);
      check("mid.tx", 32'(ser_tx), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_div = 32'd104; model_q.delete(); exp_ovr = 1'b0; exp_ferr = 1'b0;
      check("mrst.tx",  32'(ser_tx), 32'd1);
      check("mrst.div", reg_div_do, 32'd104);
      check_rx("mrst");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("mrst.hold", 32'(ser_tx), 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/soc_uart.md
Name: soc_uart

Overview:
Memory-mapped UART inside the icebreaker SoC, directly upstream of the ser_tx output pad and downstream of the ser_rx input pad. It serialises CPU-written bytes onto ser_tx as 8N1 frames. It also deserialises ser_rx frames into a small RX FIFO that the CPU reads through the data register. The baud divider is programmable through a byte-lane-writable divider register.

Parameters:
DEFAULT_DIV, 104, divider reset value in clk cycles per bit (12 MHz / 115200)
RX_DEPTH, 4, RX FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
ser_tx  output  1  serial transmit, to ser_tx pad
ser_rx  input  1  serial receive from pad, asynchronous
reg_div_we  input  4  byte-lane write enables, divider register
reg_div_di  input  32  divider write data
reg_div_do  output  32  current divider value
reg_dat_we  input  1  write request: transmit reg_dat_di[7:0]
reg_dat_re  input  1  read request: pop RX FIFO
reg_dat_di  input  32  transmit data, bits [7:0] used
reg_dat_do  output  32  RX data, or 32'hFFFF_FFFF when FIFO empty
reg_dat_wait  output  1  stall: reg_dat_we while transmitter busy
rx_overrun  output  1  sticky: byte dropped because FIFO full
rx_frame_err  output  1  sticky: stop bit sampled low
err_clr  input  1  clears both sticky flags

Behaviour:
- Single clock domain clk. Reset is synchronous, active-high, priority over all other inputs.
- Reset values: ser_tx=1, reg_div_do=DEFAULT_DIV, reg_dat_wait=0, reg_dat_do=32'hFFFF_FFFF, rx_overrun=0, rx_frame_err=0. FIFO empty; TX and RX FSMs IDLE.
- Reset mid-frame aborts the frame: ser_tx=1 on the cycle after reset; a partial RX byte is discarded.
- Divider register:
  - Each reg_div_we[i] writes byte i on the clock edge.
  - Effective bit period D = max(divider, 4) cycles. reg_div_do returns the raw stored value.
  - A divider write during a frame takes effect at the next bit boundary.
- TX FSM: IDLE, START, DATA, STOP.
  - reg_dat_wait = reg_dat_we & (TX FSM not IDLE), combinational. The CPU holds reg_dat_we until wait drops.
  - Accept: reg_dat_we=1 with FSM IDLE. The byte is latched and ser_tx drives 0 (start bit) from the next cycle.
  - Frame: start bit 0, then data bits 0..7 LSB first, then stop bit 1. Each bit lasts exactly D cycles; whole frame is 10*D cycles.
  - FSM returns to IDLE after the stop bit. A write held during the stop bit is accepted on the first IDLE cycle, giving back-to-back frames with no gap.
- RX input path: ser_rx passes through a 2-flop synchroniser (rxs). The RX FSM sees input 2 cycles late.
- RX FSM: IDLE, START, DATA, STOP.
  - IDLE -> START when rxs=0.
  - START: wait D/2 cycles (integer divide), then sample. Sample 1 = false start, go to IDLE. Sample 0 goes to DATA.
  - DATA: sample every D cycles, 8 samples, shift in LSB first.
  - STOP: sample after D cycles.
    - Sample 1: push byte into FIFO.
    - Sample 0: discard byte, set rx_frame_err.
  - STOP returns to IDLE in both cases.
- RX FIFO:
  - reg_dat_do = {24'b0, head} when non-empty, combinational.
  - reg_dat_re with FIFO non-empty pops on the clock edge. reg_dat_re on empty is a no-op.
  - Push while full: byte dropped, rx_overrun set.
  - Push and pop in the same cycle: count unchanged. When full, the pop frees the slot and the push succeeds with no overrun.
  - Push and reg_dat_re on an empty FIFO: reg_dat_do reads FFFF_FFFF that cycle and no pop occurs; the byte is visible next cycle.
  - Pointers wrap modulo RX_DEPTH.
- Sticky flags:
  - err_clr clears both flags.
  - Set and err_clr in the same cycle: set wins.

Test Plan:
- Reset then idle: ser_tx=1, reg_div_do=104, reg_dat_do=FFFF_FFFF, wait=0.
- Divider 8, write 0xA5:
  - ser_tx sequence, each bit 8 cycles: 0,1,0,1,0,0,1,0,1,1.
  - Frame is 80 cycles.
  - A second write during the frame sees wait=1 until IDLE, then its start bit follows the stop bit immediately.
- Divider 8, loop ser_tx to ser_rx, send 0x3C: reg_dat_do=0x0000_003C after the frame. reg_dat_re pops it; next read is FFFF_FFFF.
- Divider 8, external RX frames:
  - Drive 5 frames (0x01..0x05) with no reads: FIFO holds 0x01..0x04 and rx_overrun=1.
  - Pop all four in order, then pulse err_clr: rx_overrun=0.
- Divider 8:
  - Drive a 2-cycle low glitch on ser_rx: no push, no error.
  - Drive a frame with stop bit 0: no push, rx_frame_err=1.
- Byte-lane write reg_div_we=4'b0001 with di=0x0000_0002: reg_div_do=0x02 and ser_tx bit period is 4 cycles. Assert reset mid-frame: ser_tx=1 next cycle and reg_div_do=104.
